// File: rtl/nand_cpu_pkg.sv
// Shared writeback types for the nand_cpu datapath: register-file widths,
// the writeback request record and the arbiter grant encoding.
package nand_cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;
    localparam int WAIT_W     = 4;

    typedef struct packed {
        logic                  use_rw;
        logic [REG_ADDR_W-1:0] rw_addr;
        logic [DATA_W-1:0]     data;
        logic                  write_ps;
        logic                  ps;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_e;

    // Load returns always target a GPR and never touch the predicate.
    function automatic wb_req_t mem_to_req(input logic [REG_ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0]     data);
        wb_req_t r;
        r.use_rw   = 1'b1;
        r.rw_addr  = addr;
        r.data     = data;
        r.write_ps = 1'b0;
        r.ps       = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/wb_grant.sv
// Combinational writeback grant: ALU wins ties until the load-return path
// has been denied WAIT_LIMIT consecutive cycles, then mem wins.
module wb_grant
    import nand_cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 3
) (
    input  logic              alu_valid,
    input  logic              mem_valid,
    input  logic [WAIT_W-1:0] wait_cnt,
    output grant_e            grant
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    always_comb begin
        // NOTE: default assigned first so every path drives grant; no latch.
        grant = GNT_NONE;
        if (alu_valid && mem_valid) begin
            grant = (wait_cnt >= LIMIT) ? GNT_MEM : GNT_ALU;
        end else if (alu_valid) begin
            grant = GNT_ALU;
        end else if (mem_valid) begin
            grant = GNT_MEM;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter (ALU vs. load return) with a
// starvation counter for mem and a single registered writeback port.
module wb_arbiter
    import nand_cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic                  alu_use_rw,
    input  logic [REG_ADDR_W-1:0] alu_rw_addr,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  alu_write_ps,
    input  logic                  alu_ps,

    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rw_addr,
    input  logic [DATA_W-1:0]     mem_data,

    output logic                  wb_valid,
    output logic                  wb_use_rw,
    output logic [REG_ADDR_W-1:0] wb_rw_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_write_ps,
    output logic                  wb_ps,

    output logic [WAIT_W-1:0]     wait_cnt_o,
    output logic                  idle
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    logic [WAIT_W-1:0] wait_cnt;
    grant_e            grant;
    wb_req_t           alu_req;
    wb_req_t           mem_req;
    wb_req_t           wb_q;

    wb_grant #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_grant (
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .wait_cnt  (wait_cnt),
        .grant     (grant)
    );

    // Nothing is accepted while reset is held.
    assign alu_ready = !rst && (grant == GNT_ALU);
    assign mem_ready = !rst && (grant == GNT_MEM);

    assign alu_req = '{
        use_rw:   alu_use_rw,
        rw_addr:  alu_rw_addr,
        data:     alu_data,
        write_ps: alu_write_ps,
        ps:       alu_ps
    };
    assign mem_req = mem_to_req(mem_rw_addr, mem_data);

    // Counts consecutive denied mem cycles; any gap in mem_valid restarts it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            wait_cnt <= '0;
        end else if (!mem_valid || mem_ready) begin
            wait_cnt <= '0;
        end else if (wait_cnt < LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Address and data hold when idle; only the write enables drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_q     <= '0;
        end else if (alu_ready || mem_ready) begin
            wb_valid <= 1'b1;
            wb_q     <= mem_ready ? mem_req : alu_req;
        end else begin
            wb_valid       <= 1'b0;
            wb_q.use_rw    <= 1'b0;
            wb_q.write_ps  <= 1'b0;
        end
    end

    assign wb_use_rw   = wb_q.use_rw;
    assign wb_rw_addr  = wb_q.rw_addr;
    assign wb_data     = wb_q.data;
    assign wb_write_ps = wb_q.write_ps;
    assign wb_ps       = wb_q.ps;

    assign wait_cnt_o = wait_cnt;
    assign idle       = !wb_valid && !alu_valid && !mem_valid;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: table of per-cycle vectors with expected
// readies and wait count, plus a scoreboard queue for the registered wb port.
module tb_wb_arbiter;
    import nand_cpu_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  alu_valid;
    logic                  alu_ready;
    logic                  alu_use_rw;
    logic [REG_ADDR_W-1:0] alu_rw_addr;
    logic [DATA_W-1:0]     alu_data;
    logic                  alu_write_ps;
    logic                  alu_ps;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rw_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  wb_valid;
    logic                  wb_use_rw;
    logic [REG_ADDR_W-1:0] wb_rw_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_write_ps;
    logic                  wb_ps;
    logic [WAIT_W-1:0]     wait_cnt_o;
    logic                  idle;

    wb_arbiter #(
        .WAIT_LIMIT (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_use_rw   (alu_use_rw),
        .alu_rw_addr  (alu_rw_addr),
        .alu_data     (alu_data),
        .alu_write_ps (alu_write_ps),
        .alu_ps       (alu_ps),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rw_addr  (mem_rw_addr),
        .mem_data     (mem_data),
        .wb_valid     (wb_valid),
        .wb_use_rw    (wb_use_rw),
        .wb_rw_addr   (wb_rw_addr),
        .wb_data      (wb_data),
        .wb_write_ps  (wb_write_ps),
        .wb_ps        (wb_ps),
        .wait_cnt_o   (wait_cnt_o),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_valid;
        logic        alu_use_rw;
        logic [3:0]  alu_addr;
        logic [15:0] alu_data;
        logic        alu_wps;
        logic        alu_ps;
        logic        mem_valid;
        logic [3:0]  mem_addr;
        logic [15:0] mem_data;
        logic        exp_alu_ready;
        logic        exp_mem_ready;
        logic [3:0]  exp_wait;
    } vec_t;

    int tests = 0;
    int fails = 0;

    wb_req_t     exp_q[$];
    logic        exp_wb_valid = 1'b0;
    logic [3:0]  last_addr    = '0;
    logic [15:0] last_data    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_valid    = v.alu_valid;
        alu_use_rw   = v.alu_use_rw;
        alu_rw_addr  = v.alu_addr;
        alu_data     = v.alu_data;
        alu_write_ps = v.alu_wps;
        alu_ps       = v.alu_ps;
        mem_valid    = v.mem_valid;
        mem_rw_addr  = v.mem_addr;
        mem_data     = v.mem_data;
    endtask

    task automatic check_wb();
        wb_req_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wb_valid",    32'(wb_valid),    32'd1);
            check("wb_use_rw",   32'(wb_use_rw),   32'(e.use_rw));
            check("wb_rw_addr",  32'(wb_rw_addr),  32'(e.rw_addr));
            check("wb_data",     32'(wb_data),     32'(e.data));
            check("wb_write_ps", 32'(wb_write_ps), 32'(e.write_ps));
            check("wb_ps",       32'(wb_ps),       32'(e.ps));
            exp_wb_valid = 1'b1;
            last_addr    = e.rw_addr;
            last_data    = e.data;
        end else begin
            check("wb_valid_idle",    32'(wb_valid),    32'd0);
            check("wb_use_rw_idle",   32'(wb_use_rw),   32'd0);
            check("wb_write_ps_idle", 32'(wb_write_ps), 32'd0);
            check("wb_rw_addr_hold",  32'(wb_rw_addr),  32'(last_addr));
            check("wb_data_hold",     32'(wb_data),     32'(last_data));
            exp_wb_valid = 1'b0;
        end
    endtask

    // One functional cycle: drive, check readies/count, predict, clock, check wb.
    task automatic step(input vec_t v);
        wb_req_t e;
        @(negedge clk);
        rst = 1'b0;
        drive(v);
        #1;
        check("alu_ready", 32'(alu_ready),  32'(v.exp_alu_ready));
        check("mem_ready", 32'(mem_ready),  32'(v.exp_mem_ready));
        check("wait_cnt",  32'(wait_cnt_o), 32'(v.exp_wait));
        check("idle",      32'(idle),
              32'(!exp_wb_valid && !v.alu_valid && !v.mem_valid));
        if (v.alu_valid && v.exp_alu_ready) begin
            e = '{use_rw: v.alu_use_rw, rw_addr: v.alu_addr, data: v.alu_data,
                  write_ps: v.alu_wps, ps: v.alu_ps};
            exp_q.push_back(e);
        end else if (v.mem_valid && v.exp_mem_ready) begin
            e = '{use_rw: 1'b1, rw_addr: v.mem_addr, data: v.mem_data,
                  write_ps: 1'b0, ps: 1'b0};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_wb();
    endtask

    // Holds rst for n cycles with requests pending; leaves rst high on exit.
    task automatic do_reset(input int n, input logic alu_v, input logic mem_v);
        @(negedge clk);
        rst          = 1'b1;
        alu_valid    = alu_v;
        alu_use_rw   = 1'b1;
        alu_rw_addr  = 4'd5;
        alu_data     = 16'hA5A5;
        alu_write_ps = 1'b1;
        alu_ps       = 1'b1;
        mem_valid    = mem_v;
        mem_rw_addr  = 4'd7;
        mem_data     = 16'h5A5A;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_alu_ready", 32'(alu_ready), 32'd0);
            check("rst_mem_ready", 32'(mem_ready), 32'd0);
            @(posedge clk);
            #1;
            check("rst_wb_valid",    32'(wb_valid),    32'd0);
            check("rst_wb_use_rw",   32'(wb_use_rw),   32'd0);
            check("rst_wb_write_ps", 32'(wb_write_ps), 32'd0);
            check("rst_wb_ps",       32'(wb_ps),       32'd0);
            check("rst_wb_rw_addr",  32'(wb_rw_addr),  32'd0);
            check("rst_wb_data",     32'(wb_data),     32'd0);
            check("rst_wait_cnt",    32'(wait_cnt_o),  32'd0);
            if (i < n - 1) @(negedge clk);
        end
        exp_q.delete();
        exp_wb_valid = 1'b0;
        last_addr    = '0;
        last_data    = '0;
    endtask

    vec_t idle_v;
    vec_t b2b_v;
    vec_t vecs[13];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_v = '{1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0};
        drive(idle_v);

        //        aV  use  addr   data      wps  ps   mV  maddr  mdata     aR  mR  wait
        vecs[0]  = '{1'b1, 1'b1, 4'd5,  16'h1234, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'd15, 16'hFFFF, 1'b0, 1'b1, 4'd0};
        vecs[3]  = '{1'b1, 1'b1, 4'd1,  16'h0011, 1'b0, 1'b0, 1'b1, 4'd9,  16'hBEEF, 1'b1, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 1'b1, 4'd2,  16'h0022, 1'b0, 1'b0, 1'b1, 4'd9,  16'hBEEF, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{1'b1, 1'b1, 4'd3,  16'h0033, 1'b0, 1'b0, 1'b1, 4'd9,  16'hBEEF, 1'b1, 1'b0, 4'd2};
        vecs[6]  = '{1'b1, 1'b1, 4'd4,  16'h0044, 1'b1, 1'b1, 1'b1, 4'd9,  16'hBEEF, 1'b0, 1'b1, 4'd3};
        vecs[7]  = '{1'b1, 1'b1, 4'd4,  16'h0044, 1'b1, 1'b1, 1'b1, 4'd10, 16'hCAFE, 1'b1, 1'b0, 4'd0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 4'd10, 16'hCAFE, 1'b0, 1'b1, 4'd1};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[10] = '{1'b1, 1'b0, 4'd2,  16'h5555, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 4'd0};
        vecs[11] = '{1'b1, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 4'd0};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 4'd0};

        // Requests pending through reset must not be taken.
        do_reset(2, 1'b1, 1'b1);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i]);
        end

        // Four back-to-back ALU accepts keep wb_valid high with data in order.
        for (int d = 1; d <= 4; d++) begin
            b2b_v = '{1'b1, 1'b1, 4'd6, 16'(d), 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0};
            step(b2b_v);
        end
        step(idle_v);

        // Accept with mem denied, then reset drops the in-flight write and count.
        b2b_v = '{1'b1, 1'b1, 4'd7, 16'h0777, 1'b0, 1'b0, 1'b1, 4'd3, 16'h3333, 1'b1, 1'b0, 4'd0};
        step(b2b_v);
        check("pre_rst_wait_cnt", 32'(wait_cnt_o), 32'd1);
        do_reset(1, 1'b0, 1'b1);

        // First cycle after reset falls may grant.
        b2b_v = '{1'b1, 1'b1, 4'd8, 16'h0888, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0};
        step(b2b_v);
        step(idle_v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
